// File: rtl/crack_pkg.sv
// Shared constants, FSM state type and slice arithmetic for the crack scheduler.
package crack_pkg;

    localparam int DIGIT_W  = 6;
    localparam int CAND_W   = 24;
    localparam int ALPHABET = 36;
    localparam int FROM_W   = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        ABORT = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Inclusive end of a slice starting at 'from', saturated at the last symbol index.
    function automatic logic [DIGIT_W-1:0] slice_end(
        input logic [FROM_W-1:0] from,
        input logic [FROM_W-1:0] slice,
        input logic [FROM_W-1:0] last = FROM_W'(ALPHABET - 1)
    );
        logic [FROM_W:0] e;
        e = {1'b0, from} + {1'b0, slice} - 8'd1;
        if (e > {1'b0, last}) begin
            slice_end = last[DIGIT_W-1:0];
        end else begin
            slice_end = e[DIGIT_W-1:0];
        end
    endfunction

endpackage

// File: rtl/crack_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr_i, wrapping.
module rr_arbiter
    import crack_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic             gnt_valid_o
);

    // Scan N positions starting from the pointer and grant the first requester.
    always_comb begin
        int  j;
        logic taken;
        gnt_o       = '0;
        gnt_idx_o   = '0;
        gnt_valid_o = 1'b0;
        taken       = 1'b0;
        j           = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr_i) + k) % N;
            if (!taken && req_i[j]) begin
                taken       = 1'b1;
                gnt_valid_o = 1'b1;
                gnt_o[j]    = 1'b1;
                gnt_idx_o   = IDX_W'(j);
            end else begin
                taken = taken;
            end
        end
    end

endmodule

// File: rtl/crack_scheduler.sv
// Dispatches top-digit slices of the 4-symbol search space to parallel cracker
// engines, tracks busy engines and aborts everything on the first hit.
module crack_scheduler
    import crack_pkg::*;
#(
    parameter int N_WORKERS = 4,
    parameter int SLICE     = 3,
    parameter int ALPHABET  = 36
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [31:0]                 target,
    output logic [31:0]                 wrk_target,
    output logic [N_WORKERS-1:0]        wrk_start,
    output logic [5:0]                  wrk_from,
    output logic [5:0]                  wrk_to,
    output logic                        wrk_abort,
    input  logic [N_WORKERS-1:0]        wrk_done,
    input  logic [N_WORKERS-1:0]        wrk_found,
    input  logic [24*N_WORKERS-1:0]     wrk_cand,
    output logic                        busy,
    output logic                        done,
    output logic                        found,
    output logic [23:0]                 result,
    output logic [6:0]                  slices_issued
);

    localparam int PTR_W = $clog2(N_WORKERS);
    localparam logic [FROM_W-1:0] LAST_FROM = FROM_W'(ALPHABET - 1);

    state_t                 state_q, state_d;
    logic [N_WORKERS-1:0]   wbusy_q, wbusy_d;
    logic [FROM_W-1:0]      next_from_q, next_from_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic [31:0]            target_q, target_d;
    logic [N_WORKERS-1:0]   wrk_start_q, wrk_start_d;
    logic [5:0]             wrk_from_q, wrk_from_d;
    logic [5:0]             wrk_to_q, wrk_to_d;
    logic                   wrk_abort_q, wrk_abort_d;
    logic                   found_q, found_d;
    logic [23:0]            result_q, result_d;
    logic [6:0]             slices_q, slices_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic [N_WORKERS-1:0]   gnt_s;
    logic [PTR_W-1:0]       gnt_idx_s;
    logic                   gnt_valid_s;
    logic [N_WORKERS-1:0]   hit_v_s;
    logic                   hit_s;
    logic [CAND_W-1:0]      hit_cand_s;

    rr_arbiter #(
        .N     (N_WORKERS),
        .IDX_W (PTR_W)
    ) u_arb (
        .req_i       (~wbusy_q),
        .ptr_i       (ptr_q),
        .gnt_o       (gnt_s),
        .gnt_idx_o   (gnt_idx_s),
        .gnt_valid_o (gnt_valid_s)
    );

    // Lowest-index busy engine reporting a match wins; found from idle engines is dropped.
    always_comb begin
        hit_v_s    = wrk_found & wbusy_q;
        hit_s      = |hit_v_s;
        hit_cand_s = '0;
        for (int i = N_WORKERS - 1; i >= 0; i--) begin
            hit_cand_s = hit_v_s[i] ? wrk_cand[i*CAND_W +: CAND_W] : hit_cand_s;
        end
    end

    // Next-state and next-output logic for the scheduler FSM.
    always_comb begin
        state_d     = state_q;
        wbusy_d     = wbusy_q & ~wrk_done;
        next_from_d = next_from_q;
        ptr_d       = ptr_q;
        target_d    = target_q;
        wrk_start_d = '0;
        wrk_from_d  = wrk_from_q;
        wrk_to_d    = wrk_to_q;
        wrk_abort_d = wrk_abort_q;
        found_d     = found_q;
        result_d    = result_q;
        slices_d    = slices_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    target_d    = target;
                    found_d     = 1'b0;
                    result_d    = 24'd0;
                    slices_d    = 7'd0;
                    next_from_d = 7'd0;
                    wrk_abort_d = 1'b0;
                    state_d     = RUN;
                end else begin
                    state_d = state_q;
                end
            end
            RUN: begin
                if (hit_s) begin
                    found_d     = 1'b1;
                    result_d    = hit_cand_s;
                    wrk_abort_d = 1'b1;
                    state_d     = ABORT;
                end else if ((next_from_q <= LAST_FROM) && gnt_valid_s) begin
                    wrk_start_d = gnt_s;
                    wrk_from_d  = next_from_q[5:0];
                    wrk_to_d    = slice_end(next_from_q, FROM_W'(SLICE), LAST_FROM);
                    wbusy_d     = wbusy_d | gnt_s;
                    next_from_d = next_from_q + FROM_W'(SLICE);
                    ptr_d       = (gnt_idx_s == PTR_W'(N_WORKERS - 1)) ? '0 : gnt_idx_s + PTR_W'(1);
                    slices_d    = slices_q + 7'd1;
                end else if ((next_from_q > LAST_FROM) && (wbusy_q == '0)) begin
                    state_d = DONE;
                end else begin
                    state_d = state_q;
                end
            end
            ABORT: begin
                if (wbusy_q == '0) begin
                    wrk_abort_d = 1'b0;
                    state_d     = DONE;
                end else begin
                    wrk_abort_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == RUN) || (state_d == ABORT);
        done_d = (state_d == DONE);
    end

    // State and registered outputs; rst returns everything to zero immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wbusy_q     <= '0;
            next_from_q <= 7'd0;
            ptr_q       <= '0;
            target_q    <= 32'd0;
            wrk_start_q <= '0;
            wrk_from_q  <= 6'd0;
            wrk_to_q    <= 6'd0;
            wrk_abort_q <= 1'b0;
            found_q     <= 1'b0;
            result_q    <= 24'd0;
            slices_q    <= 7'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wbusy_q     <= wbusy_d;
            next_from_q <= next_from_d;
            ptr_q       <= ptr_d;
            target_q    <= target_d;
            wrk_start_q <= wrk_start_d;
            wrk_from_q  <= wrk_from_d;
            wrk_to_q    <= wrk_to_d;
            wrk_abort_q <= wrk_abort_d;
            found_q     <= found_d;
            result_q    <= result_d;
            slices_q    <= slices_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign wrk_target    = target_q;
    assign wrk_start     = wrk_start_q;
    assign wrk_from      = wrk_from_q;
    assign wrk_to        = wrk_to_q;
    assign wrk_abort     = wrk_abort_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign found         = found_q;
    assign result        = result_q;
    assign slices_issued = slices_q;

endmodule

// File: tb/tb_crack_scheduler.sv
// Directed bench: two schedulers (SLICE=3 and SLICE=5) driven by simple engine models.
module tb_crack_scheduler;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    typedef struct {
        int worker;
        int from;
        int to;
    } disp_t;

    int n_cmp = 0;
    int n_err = 0;

    // ---------------- DUT A: N=4, SLICE=3 ----------------
    logic        a_start;
    logic [31:0] a_target, a_wtarget;
    logic [3:0]  a_wstart, a_mdone, a_xdone, a_mfound, a_done_in;
    logic [5:0]  a_wfrom, a_wto;
    logic        a_wabort, a_busy, a_done, a_found;
    logic [95:0] a_mcand;
    logic [23:0] a_result;
    logic [6:0]  a_slices;
    assign a_done_in = a_mdone | a_xdone;

    crack_scheduler #(.N_WORKERS(4), .SLICE(3), .ALPHABET(36)) u_dut_a (
        .clk(clk), .rst(rst), .start(a_start), .target(a_target),
        .wrk_target(a_wtarget), .wrk_start(a_wstart), .wrk_from(a_wfrom), .wrk_to(a_wto),
        .wrk_abort(a_wabort), .wrk_done(a_done_in), .wrk_found(a_mfound), .wrk_cand(a_mcand),
        .busy(a_busy), .done(a_done), .found(a_found), .result(a_result),
        .slices_issued(a_slices)
    );

    // ---------------- DUT B: N=4, SLICE=5 ----------------
    logic        b_start;
    logic [31:0] b_target, b_wtarget;
    logic [3:0]  b_wstart, b_mdone, b_xdone, b_mfound, b_done_in;
    logic [5:0]  b_wfrom, b_wto;
    logic        b_wabort, b_busy, b_done, b_found;
    logic [95:0] b_mcand;
    logic [23:0] b_result;
    logic [6:0]  b_slices;
    assign b_done_in = b_mdone | b_xdone;

    crack_scheduler #(.N_WORKERS(4), .SLICE(5), .ALPHABET(36)) u_dut_b (
        .clk(clk), .rst(rst), .start(b_start), .target(b_target),
        .wrk_target(b_wtarget), .wrk_start(b_wstart), .wrk_from(b_wfrom), .wrk_to(b_wto),
        .wrk_abort(b_wabort), .wrk_done(b_done_in), .wrk_found(b_mfound), .wrk_cand(b_mcand),
        .busy(b_busy), .done(b_done), .found(b_found), .result(b_result),
        .slices_issued(b_slices)
    );

    disp_t got_a[$];
    disp_t got_b[$];
    int    a_cnt[4];
    int    b_cnt[4];

    function automatic int onehot_idx(input logic [3:0] v);
        if ($countones(v) != 1) return 99;
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return 99;
    endfunction

    // Record every dispatch seen on either scheduler.
    always @(negedge clk) begin
        if (a_wstart != 4'd0) got_a.push_back('{onehot_idx(a_wstart), int'(a_wfrom), int'(a_wto)});
        if (b_wstart != 4'd0) got_b.push_back('{onehot_idx(b_wstart), int'(b_wfrom), int'(b_wto)});
    end

    // Engine models: done 5 cycles after start, or on the cycle abort is seen.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            a_mdone[i] = 1'b0;
            if (rst) a_cnt[i] = 0;
            else if (a_wstart[i]) a_cnt[i] = 5;
            else if (a_cnt[i] != 0) begin
                if (a_wabort) begin a_cnt[i] = 0; a_mdone[i] = 1'b1; end
                else begin a_cnt[i]--; if (a_cnt[i] == 0) a_mdone[i] = 1'b1; end
            end
            b_mdone[i] = 1'b0;
            if (rst) b_cnt[i] = 0;
            else if (b_wstart[i]) b_cnt[i] = 5;
            else if (b_cnt[i] != 0) begin
                if (b_wabort) begin b_cnt[i] = 0; b_mdone[i] = 1'b1; end
                else begin b_cnt[i]--; if (b_cnt[i] == 0) b_mdone[i] = 1'b1; end
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic start_a(input logic [31:0] t);
        a_start = 1'b1; a_target = t; cyc(); a_start = 1'b0;
    endtask

    task automatic start_b(input logic [31:0] t);
        b_start = 1'b1; b_target = t; cyc(); b_start = 1'b0;
    endtask

    task automatic wait_done(input bit sel, input string nm);
        int n = 0;
        while (((sel ? b_done : a_done) !== 1'b1) && n < 400) begin cyc(); n++; end
        chk(nm, {31'd0, (sel ? b_done : a_done)}, 32'd1);
    endtask

    task automatic wait_disp(input bit sel, input int cnt, input string nm);
        int n = 0;
        while (((sel ? got_b.size() : got_a.size()) < cnt) && n < 50) begin cyc(); n++; end
        chk(nm, sel ? got_b.size() : got_a.size(), cnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    disp_t exp_a[12];
    disp_t exp_b[8];

    initial begin
        rst = 1'b1;
        a_start = 1'b0; a_target = 32'd0; a_xdone = 4'd0; a_mfound = 4'd0; a_mcand = '0;
        b_start = 1'b0; b_target = 32'd0; b_xdone = 4'd0; b_mfound = 4'd0; b_mcand = '0;

        for (int k = 0; k < 12; k++) exp_a[k] = '{k % 4, 3 * k, 3 * k + 2};
        exp_b[0] = '{0,  0,  4};
        exp_b[1] = '{1,  5,  9};
        exp_b[2] = '{2, 10, 14};
        exp_b[3] = '{3, 15, 19};
        exp_b[4] = '{0, 20, 24};
        exp_b[5] = '{1, 25, 29};
        exp_b[6] = '{2, 30, 34};
        exp_b[7] = '{3, 35, 35};

        // ---- reset state ----
        repeat (3) cyc();
        chk("rst_flags_a", {24'd0, a_busy, a_done, a_found, a_wabort, a_wstart}, 32'd0);
        chk("rst_data_a", {1'b0, a_slices, a_result}, 32'd0);
        chk("rst_target_a", a_wtarget, 32'd0);
        rst = 1'b0;
        repeat (20) cyc();
        chk("idle_no_dispatch_a", got_a.size(), 0);
        chk("idle_no_dispatch_b", got_b.size(), 0);
        chk("idle_flags_b", {24'd0, b_busy, b_done, b_found, b_wabort, b_wstart}, 32'd0);

        // ---- A: full search, no match ----
        got_a.delete();
        start_a(32'h64636261);
        chk("first_latency_a", got_a.size(), 0);
        chk("target_latch_a", a_wtarget, 32'h64636261);
        chk("busy_run_a", {31'd0, a_busy}, 32'd1);
        cyc();
        chk("first_dispatch_a", got_a.size(), 1);
        cyc();
        a_start = 1'b1; a_target = 32'h11111111; cyc(); a_start = 1'b0;
        wait_done(1'b0, "nomatch_done_a");
        chk("nomatch_count_a", got_a.size(), 12);
        for (int k = 0; k < 12 && k < got_a.size(); k++) begin
            chk($sformatf("disp%0d_worker_a", k), got_a[k].worker, exp_a[k].worker);
            chk($sformatf("disp%0d_from_a", k), got_a[k].from, exp_a[k].from);
            chk($sformatf("disp%0d_to_a", k), got_a[k].to, exp_a[k].to);
        end
        chk("nomatch_found_a", {31'd0, a_found}, 32'd0);
        chk("nomatch_slices_a", {25'd0, a_slices}, 32'd12);
        chk("nomatch_busy_a", {31'd0, a_busy}, 32'd0);
        chk("ignored_start_target_a", a_wtarget, 32'h64636261);
        repeat (3) cyc();
        chk("done_holds_a", {31'd0, a_done}, 32'd1);

        // ---- A: worker 2 finds {6,1,2,7} ----
        got_a.delete();
        start_a(32'h61616161);
        chk("restart_clears_a", {4'd0, a_done, a_found, a_slices, a_result}, 32'd0);
        wait_disp(1'b0, 4, "hit_wait_disp_a");
        a_mfound = 4'b0100; a_mcand = '0; a_mcand[2*24 +: 24] = 24'h181087;
        cyc();
        a_mfound = 4'd0;
        chk("hit_found_a", {31'd0, a_found}, 32'd1);
        chk("hit_result_a", {8'd0, a_result}, 32'h00181087);
        chk("hit_abort_a", {31'd0, a_wabort}, 32'd1);
        wait_done(1'b0, "hit_done_a");
        chk("hit_result_final_a", {8'd0, a_result}, 32'h00181087);
        chk("hit_abort_low_a", {31'd0, a_wabort}, 32'd0);
        chk("hit_no_more_dispatch_a", got_a.size(), 4);
        chk("hit_slices_a", {25'd0, a_slices}, 32'd4);

        // ---- A: workers 1 and 3 find on the same cycle ----
        got_a.delete();
        start_a(32'h62626262);
        wait_disp(1'b0, 4, "dual_wait_disp_a");
        a_mfound = 4'b1010; a_mcand = '0;
        a_mcand[1*24 +: 24] = 24'h044009;
        a_mcand[3*24 +: 24] = 24'h28B0C2;
        cyc();
        a_mfound = 4'b1000; a_mcand[3*24 +: 24] = 24'h3FFFFF;
        cyc();
        a_mfound = 4'd0;
        chk("dual_result_a", {8'd0, a_result}, 32'h00044009);
        wait_done(1'b0, "dual_done_a");
        a_mfound = 4'b1000; cyc(); a_mfound = 4'd0; cyc();
        chk("dual_found_a", {31'd0, a_found}, 32'd1);
        chk("dual_result_final_a", {8'd0, a_result}, 32'h00044009);

        // ---- A: asynchronous reset mid-run ----
        got_a.delete();
        start_a(32'h63636363);
        wait_disp(1'b0, 3, "rst_wait_disp_a");
        #2 rst = 1'b1;
        #1;
        chk("midrst_flags_a", {24'd0, a_busy, a_done, a_found, a_wabort, a_wstart}, 32'd0);
        chk("midrst_slices_a", {25'd0, a_slices}, 32'd0);
        chk("midrst_target_a", a_wtarget, 32'd0);
        cyc();
        rst = 1'b0;
        cyc();
        got_a.delete();
        start_a(32'h64646464);
        cyc();
        chk("postrst_count_a", got_a.size(), 1);
        if (got_a.size() > 0) begin
            chk("postrst_worker_a", got_a[0].worker, 0);
            chk("postrst_from_a", got_a[0].from, 0);
        end
        chk("postrst_slices_a", {25'd0, b_busy ? 7'd99 : a_slices}, 32'd1);
        wait_done(1'b0, "postrst_done_a");

        // ---- B: SLICE=5, no match; stray found from an idle worker ----
        got_b.delete();
        start_b(32'h41424344);
        cyc();
        b_mfound = 4'b1000; b_mcand = '0; b_mcand[3*24 +: 24] = 24'h3FFFFF;
        cyc();
        b_mfound = 4'd0;
        wait_done(1'b1, "nomatch_done_b");
        chk("nomatch_count_b", got_b.size(), 8);
        for (int k = 0; k < 8 && k < got_b.size(); k++) begin
            chk($sformatf("disp%0d_worker_b", k), got_b[k].worker, exp_b[k].worker);
            chk($sformatf("disp%0d_from_b", k), got_b[k].from, exp_b[k].from);
            chk($sformatf("disp%0d_to_b", k), got_b[k].to, exp_b[k].to);
        end
        chk("nomatch_found_b", {31'd0, b_found}, 32'd0);
        chk("nomatch_slices_b", {25'd0, b_slices}, 32'd8);

        // ---- B: found and done on the same cycle from worker 0 ----
        got_b.delete();
        start_b(32'h45464748);
        wait_disp(1'b1, 2, "fd_wait_disp_b");
        b_mfound = 4'b0001; b_xdone = 4'b0001; b_mcand = '0; b_mcand[23:0] = 24'h8C0445;
        cyc();
        b_mfound = 4'd0; b_xdone = 4'd0;
        wait_done(1'b1, "fd_done_b");
        chk("fd_found_b", {31'd0, b_found}, 32'd1);
        chk("fd_result_b", {8'd0, b_result}, 32'h008C0445);
        chk("fd_no_more_dispatch_b", got_b.size(), 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
